axis_packet_arbiter: RTL and testbench



---
 rtl/axis_packet_arbiter.sv | 151 +++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream egress between
// NUM_STREAMS sources, with a programmable dead time after every packet.
module axis_packet_arbiter #(
   parameter int NUM_STREAMS = 2,
   parameter int AXIS_BYTES  = 1,
   parameter int GAP_CYCLES  = 0
) (
   input  logic                                clk,
   input  logic                                sreset,
   output logic [NUM_STREAMS-1:0]              axis_i_tready,
   input  logic [NUM_STREAMS-1:0]              axis_i_tvalid,
   input  logic [NUM_STREAMS-1:0]              axis_i_tlast,
   input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
   input  logic                                axis_o_tready,
   output logic                                axis_o_tvalid,
   output logic                                axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0]             axis_o_tdata,
   output logic [NUM_STREAMS-1:0]              grant,
   output logic                                busy
);

   localparam int DW = AXIS_BYTES * 8;
   localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef logic [IW-1:0] idx_t;
   typedef logic [CW-1:0] cnt_t;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam idx_t LAST_IDX = idx_t'(NUM_STREAMS - 1);
   localparam cnt_t GAP_LOAD = (GAP_CYCLES > 0) ? cnt_t'(GAP_CYCLES - 1) : cnt_t'(0);

   state_t                 state_q, state_d;
   logic [NUM_STREAMS-1:0] grant_q, grant_d;
   idx_t                   last_q, last_d;
   cnt_t                   gap_q, gap_d;
   logic                   busy_q, busy_d;

   logic                   found_s;
   idx_t                   win_s;
   logic                   tvalid_s;
   logic                   tlast_s;
   logic [DW-1:0]          tdata_s;
   logic                   eop_s;

   // Round-robin search: indices above last_q first, then wrap to 0..last_q.
   always_comb begin
      logic hit_v;
      found_s = 1'b0;
      win_s   = '0;
      hit_v   = 1'b0;
      for (int j = 0; j < NUM_STREAMS; j++) begin
         hit_v   = !found_s && axis_i_tvalid[j] && (idx_t'(j) > last_q);
         win_s   = hit_v ? idx_t'(j) : win_s;
         found_s = found_s | hit_v;
      end
      for (int j = 0; j < NUM_STREAMS; j++) begin
         hit_v   = !found_s && axis_i_tvalid[j] && (idx_t'(j) <= last_q);
         win_s   = hit_v ? idx_t'(j) : win_s;
         found_s = found_s | hit_v;
      end
   end

   // Egress mux; grant_q is zero outside PASS, so stream 0 data leaks through idle.
   always_comb begin
      tvalid_s = 1'b0;
      tlast_s  = 1'b0;
      tdata_s  = axis_i_tdata[DW-1:0];
      for (int j = 0; j < NUM_STREAMS; j++) begin
         tvalid_s = grant_q[j] ? axis_i_tvalid[j]          : tvalid_s;
         tlast_s  = grant_q[j] ? axis_i_tlast[j]           : tlast_s;
         tdata_s  = grant_q[j] ? axis_i_tdata[j*DW +: DW]  : tdata_s;
      end
      eop_s = tvalid_s & tlast_s & axis_o_tready;
   end

   assign axis_o_tvalid = tvalid_s;
   assign axis_o_tlast  = tlast_s;
   assign axis_o_tdata  = tdata_s;
   assign axis_i_tready = grant_q & {NUM_STREAMS{axis_o_tready}};
   assign grant         = grant_q;
   assign busy          = busy_q;

   // Next-state logic for the IDLE/PASS/GAP controller.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               state_d = ST_PASS;
               last_d  = win_s;
               for (int j = 0; j < NUM_STREAMS; j++) begin
                  grant_d[j] = (idx_t'(j) == win_s);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PASS: begin
            if (eop_s) begin
               grant_d = '0;
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_PASS;
            end
         end
         ST_GAP: begin
            if (gap_q == cnt_t'(0)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - cnt_t'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State registers; sreset overrides any transition including end of packet.
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LAST_IDX;
         gap_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: randomized sources checked cycle by cycle
// against a round-robin/gap reference model built from integers.
module tb_axis_packet_arbiter;

   localparam int N   = 3;
   localparam int GAP = 3;
   localparam int W   = 8;

   logic           clk = 1'b0;
   logic           sreset;
   logic [N-1:0]   axis_i_tready;
   logic [N-1:0]   axis_i_tvalid;
   logic [N-1:0]   axis_i_tlast;
   logic [N*W-1:0] axis_i_tdata;
   logic           axis_o_tready;
   logic           axis_o_tvalid;
   logic           axis_o_tlast;
   logic [W-1:0]   axis_o_tdata;
   logic [N-1:0]   grant;
   logic           busy;

   always #5 clk = ~clk;

   axis_packet_arbiter #(
      .NUM_STREAMS (N),
      .AXIS_BYTES  (1),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk           (clk),
      .sreset        (sreset),
      .axis_i_tready (axis_i_tready),
      .axis_i_tvalid (axis_i_tvalid),
      .axis_i_tlast  (axis_i_tlast),
      .axis_i_tdata  (axis_i_tdata),
      .axis_o_tready (axis_o_tready),
      .axis_o_tvalid (axis_o_tvalid),
      .axis_o_tlast  (axis_o_tlast),
      .axis_o_tdata  (axis_o_tdata),
      .grant         (grant),
      .busy          (busy)
   );

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // source scripts
   int beat [N];
   int plen [N];
   int pkt_no [N];
   int vpct [N];
   int rpct;

   // reference model: owner stream (-1 none), last served, dead cycles left
   int own;
   int last_g;
   int quiet;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < N; k++) begin
         axis_i_tvalid[k] = ($urandom_range(99) < vpct[k]);
         axis_i_tlast[k]  = (beat[k] == plen[k] - 1);
         axis_i_tdata[k*W +: W] = 8'(k * 64 + (pkt_no[k] % 4) * 16 + beat[k]);
      end
      axis_o_tready = ($urandom_range(99) < rpct);
   endtask

   task automatic cycle(input logic rst);
      logic [N-1:0] exp_ready;
      logic [N-1:0] exp_grant;
      logic [N-1:0] hs;
      logic         exp_valid;
      logic         exp_last;
      logic [W-1:0] exp_data;
      logic         exp_busy;
      logic         found;
      int           c;
      sreset = rst;
      drive_inputs();
      @(negedge clk);
      exp_ready = '0;
      exp_grant = '0;
      if (own >= 0) begin
         exp_grant[own] = 1'b1;
         exp_ready[own] = axis_o_tready;
         exp_valid = axis_i_tvalid[own];
         exp_last  = axis_i_tlast[own];
         exp_data  = axis_i_tdata[own*W +: W];
         exp_busy  = 1'b1;
      end else begin
         exp_valid = 1'b0;
         exp_last  = 1'b0;
         exp_data  = axis_i_tdata[W-1:0];
         exp_busy  = (quiet > 0);
      end
      chk("o_tvalid", 32'(axis_o_tvalid), 32'(exp_valid));
      chk("o_tlast",  32'(axis_o_tlast),  32'(exp_last));
      chk("o_tdata",  32'(axis_o_tdata),  32'(exp_data));
      chk("i_tready", 32'(axis_i_tready), 32'(exp_ready));
      chk("grant",    32'(grant),         32'(exp_grant));
      chk("busy",     32'(busy),          32'(exp_busy));
      hs = axis_i_tready & axis_i_tvalid;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (hs[k]) begin
            if (beat[k] == plen[k] - 1) begin
               beat[k] = 0;
               pkt_no[k]++;
               plen[k] = $urandom_range(1, 5);
            end else begin
               beat[k]++;
            end
         end
      end
      if (rst) begin
         own    = -1;
         last_g = N - 1;
         quiet  = 0;
      end else if (own >= 0) begin
         if (axis_i_tvalid[own] && axis_o_tready && axis_i_tlast[own]) begin
            own   = -1;
            quiet = GAP;
         end
      end else if (quiet > 0) begin
         quiet--;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            c = (last_g + k) % N;
            if (!found && axis_i_tvalid[c]) begin
               found  = 1'b1;
               own    = c;
               last_g = c;
            end
         end
      end
      #1;
   endtask

   initial begin
      int guard;
      own    = -1;
      last_g = N - 1;
      quiet  = 0;
      rpct   = 100;
      for (int k = 0; k < N; k++) begin
         beat[k]   = 0;
         plen[k]   = 4;
         pkt_no[k] = 0;
         vpct[k]   = 0;
      end
      sreset = 1'b1;
      drive_inputs();
      @(posedge clk);
      #1;

      // reset state
      cycle(1'b1);
      cycle(1'b1);

      // single stream, open egress
      vpct[0] = 100;
      for (int i = 0; i < 20; i++) cycle(1'b0);

      // all streams continuously valid: strict rotation
      for (int k = 0; k < N; k++) vpct[k] = 100;
      for (int i = 0; i < 60; i++) cycle(1'b0);

      // back-pressure and source bubbles
      for (int k = 0; k < N; k++) vpct[k] = 70;
      rpct = 50;
      for (int i = 0; i < 200; i++) cycle(1'b0);

      // reset on the second beat of a packet, then rearbitrate from stream 0
      for (int k = 0; k < N; k++) vpct[k] = 100;
      rpct  = 100;
      guard = 0;
      while (!(own >= 0 && beat[(own < 0) ? 0 : own] == 1) && guard < 100) begin
         cycle(1'b0);
         guard++;
      end
      chk("reach_second_beat", 32'(guard < 100), 32'd1);
      cycle(1'b1);
      for (int i = 0; i < 30; i++) cycle(1'b0);

      // only streams 0 and 2 request: stream 1 never granted
      vpct[1] = 0;
      for (int i = 0; i < 60; i++) cycle(1'b0);

      // long random run with occasional resets
      for (int blk = 0; blk < 20; blk++) begin
         for (int k = 0; k < N; k++) vpct[k] = $urandom_range(100);
         rpct = $urandom_range(30, 100);
         for (int i = 0; i < 100; i++) cycle($urandom_range(199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
